// File: rtl/maxnet_controller.sv
// ----------------------------------------------------------------------------
// maxnet_controller
//
// Sequencing controller for the four-lane MaxNet processing-unit array.
// A run latches four activations, then repeats multiply -> accumulate ->
// write-back iterations on the PUs until at most one lane is still nonzero
// or the iteration limit is reached. The lowest-index surviving lane is
// reported as the winner with a start/done handshake.
//
// Parameters
//   W         activation width (two's complement, 3 fractional bits)
//   MAX_ITER  iteration limit, 1..15
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a run (only honoured in IDLE)
//   in_x0..in_x3             initial activations, sampled with start
//   x0..x3                   current state vector driven to all PUs
//   mult_reg_en, add_reg_en  PU multiply / accumulate register strobes
//   pu_new0..pu_new3         PU new_value per lane
//   pu_zero0..pu_zero3       PU Zero_signal per lane
//   busy                     run in progress
//   done                     one-cycle completion pulse
//   winner, winner_valid     lowest-index surviving lane and its validity
//   iter_count               iterations completed in current/last run
// ----------------------------------------------------------------------------
module maxnet_controller #(
    parameter int W        = 5,
    parameter int MAX_ITER = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] in_x0,
    input  logic [W-1:0] in_x1,
    input  logic [W-1:0] in_x2,
    input  logic [W-1:0] in_x3,
    output logic [W-1:0] x0,
    output logic [W-1:0] x1,
    output logic [W-1:0] x2,
    output logic [W-1:0] x3,
    output logic         mult_reg_en,
    output logic         add_reg_en,
    input  logic [W-1:0] pu_new0,
    input  logic [W-1:0] pu_new1,
    input  logic [W-1:0] pu_new2,
    input  logic [W-1:0] pu_new3,
    input  logic         pu_zero0,
    input  logic         pu_zero1,
    input  logic         pu_zero2,
    input  logic         pu_zero3,
    output logic         busy,
    output logic         done,
    output logic [1:0]   winner,
    output logic         winner_valid,
    output logic [3:0]   iter_count
);

    localparam logic [3:0] ITER_LIMIT = 4'(MAX_ITER);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        ADD,
        UPDATE,
        CHECK,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] nz;
    logic       nz_at_most_one;
    logic [1:0] nz_lowest;

    // Clearing the lowest set bit leaves zero only when zero or one lane is set.
    always_comb begin
        nz_at_most_one = ((nz & (nz - 4'd1)) == 4'd0);
    end

    // Lowest-index nonzero lane; an all-zero vector reports lane 0.
    always_comb begin
        nz_lowest = 2'd0;
        if (nz[0])      nz_lowest = 2'd0;
        else if (nz[1]) nz_lowest = 2'd1;
        else if (nz[2]) nz_lowest = 2'd2;
        else if (nz[3]) nz_lowest = 2'd3;
    end

    // Strobes, busy and done are registered and set on the edge that enters
    // the state they belong to, so each is high for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x0           <= '0;
            x1           <= '0;
            x2           <= '0;
            x3           <= '0;
            mult_reg_en  <= 1'b0;
            add_reg_en   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner       <= 2'd0;
            winner_valid <= 1'b0;
            iter_count   <= 4'd0;
            nz           <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x0           <= in_x0;
                        x1           <= in_x1;
                        x2           <= in_x2;
                        x3           <= in_x3;
                        iter_count   <= 4'd0;
                        winner_valid <= 1'b0;
                        busy         <= 1'b1;
                        mult_reg_en  <= 1'b1;
                        state        <= MULT;
                    end
                end
                MULT: begin
                    mult_reg_en <= 1'b0;
                    add_reg_en  <= 1'b1;
                    state       <= ADD;
                end
                ADD: begin
                    add_reg_en <= 1'b0;
                    state      <= UPDATE;
                end
                UPDATE: begin
                    x0 <= pu_new0;
                    x1 <= pu_new1;
                    x2 <= pu_new2;
                    x3 <= pu_new3;
                    nz <= ~{pu_zero3, pu_zero2, pu_zero1, pu_zero0};
                    if (iter_count != 4'hF) begin
                        iter_count <= iter_count + 4'd1;
                    end
                    state <= CHECK;
                end
                CHECK: begin
                    // Tie at the limit still resolves to the lowest surviving lane.
                    if (nz_at_most_one || (iter_count == ITER_LIMIT)) begin
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        winner       <= nz_lowest;
                        winner_valid <= |nz;
                        state        <= DONE;
                    end else begin
                        mult_reg_en <= 1'b1;
                        state       <= MULT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mult_reg_en <= 1'b0;
                    add_reg_en  <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// ----------------------------------------------------------------------------
// tb_maxnet_controller
//
// Self-checking bench for maxnet_controller (instantiated with MAX_ITER=4).
// A small PU model answers each iteration with a per-run schedule of lanes
// to zero and fixed surviving values. A table of runs is applied in a loop,
// followed by hand-written start-during-ADD and reset-during-CHECK sequences.
// ----------------------------------------------------------------------------
module tb_maxnet_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] in_x [4];
    logic [4:0] x [4];
    logic [4:0] pu_new [4];
    logic [3:0] pu_zero;
    logic       mult_reg_en;
    logic       add_reg_en;
    logic       busy;
    logic       done;
    logic [1:0] winner;
    logic       winner_valid;
    logic [3:0] iter_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maxnet_controller #(.W(5), .MAX_ITER(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_x0        (in_x[0]),
        .in_x1        (in_x[1]),
        .in_x2        (in_x[2]),
        .in_x3        (in_x[3]),
        .x0           (x[0]),
        .x1           (x[1]),
        .x2           (x[2]),
        .x3           (x[3]),
        .mult_reg_en  (mult_reg_en),
        .add_reg_en   (add_reg_en),
        .pu_new0      (pu_new[0]),
        .pu_new1      (pu_new[1]),
        .pu_new2      (pu_new[2]),
        .pu_new3      (pu_new[3]),
        .pu_zero0     (pu_zero[0]),
        .pu_zero1     (pu_zero[1]),
        .pu_zero2     (pu_zero[2]),
        .pu_zero3     (pu_zero[3]),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_valid (winner_valid),
        .iter_count   (iter_count)
    );

    // One run: inputs, PU behaviour per iteration, and expected results.
    typedef struct {
        logic [3:0][4:0] in_x;
        logic [3:0][4:0] keep;
        logic [4:1][3:0] zero_sched;
        int              exp_lat;
        logic [3:0]      exp_iter;
        logic [1:0]      exp_win;
        logic            exp_wv;
        logic [3:0][4:0] exp_x;
    } vec_t;

    vec_t vecs [6];
    vec_t cur;

    int mult_cnt    = 0;
    int add_cnt     = 0;
    int done_cnt    = 0;
    int overlap_cnt = 0;
    int base_mult   = 0;

    // Count strobes mid-cycle; mult_cnt then names the iteration in progress.
    always @(negedge clk) begin
        if (mult_reg_en) mult_cnt <= mult_cnt + 1;
        if (add_reg_en) add_cnt <= add_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mult_reg_en && add_reg_en) overlap_cnt <= overlap_cnt + 1;
    end

    // PU model: zero the scheduled lanes, others return their keep value.
    int         sched_it;
    logic [2:0] sched_idx;
    always_comb begin
        sched_it  = mult_cnt - base_mult;
        sched_idx = 3'd1;
        pu_zero   = 4'b0000;
        if (sched_it >= 1 && sched_it <= 4) begin
            sched_idx = 3'(sched_it);
            pu_zero   = cur.zero_sched[sched_idx];
        end
        for (int i = 0; i < 4; i++) begin
            pu_new[i] = pu_zero[i] ? 5'd0 : cur.keep[i];
        end
    end

    function automatic vec_t mkVec(
        input logic [3:0][4:0] ix, input logic [3:0][4:0] kp,
        input logic [4:1][3:0] zs, input int lat, input logic [3:0] it,
        input logic [1:0] wn, input logic wv, input logic [3:0][4:0] ex);
        vec_t v;
        v.in_x       = ix;
        v.keep       = kp;
        v.zero_sched = zs;
        v.exp_lat    = lat;
        v.exp_iter   = it;
        v.exp_win    = wn;
        v.exp_wv     = wv;
        v.exp_x      = ex;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({x[3], x[2], x[1], x[0], mult_reg_en, add_reg_en, busy, done,
                    winner, winner_valid, iter_count});
    endfunction

    // Run one vector; optionally pulse start during the first ADD cycle.
    task automatic applyStimulus(input vec_t v, input bit pulse_in_add, output int lat);
        cur       = v;
        base_mult = mult_cnt;
        @(negedge clk);
        for (int i = 0; i < 4; i++) in_x[i] = v.in_x[i];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("mult_first_cycle", 32'({mult_reg_en, add_reg_en}), 32'b10);
        checkOutput("x_loaded", 32'({x[3], x[2], x[1], x[0]}), 32'(v.in_x));
        if (pulse_in_add) begin
            @(posedge clk);
            #1;
            lat = 2;
            checkOutput("add_second_cycle", 32'({mult_reg_en, add_reg_en}), 32'b01);
            start = 1'b1;
            @(posedge clk);
            #1;
            lat   = 3;
            start = 1'b0;
        end
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runAndCheck(input int idx, input bit pulse_in_add);
        int lat;
        int m0, a0, d0;
        vec_t v;
        v  = vecs[idx];
        m0 = mult_cnt;
        a0 = add_cnt;
        d0 = done_cnt;
        applyStimulus(v, pulse_in_add, lat);
        checkOutput($sformatf("v%0d_done_latency", idx), 32'(lat), 32'(v.exp_lat));
        checkOutput($sformatf("v%0d_busy_at_done", idx), 32'(busy), 32'd0);
        checkOutput($sformatf("v%0d_iter_count", idx), 32'(iter_count), 32'(v.exp_iter));
        checkOutput($sformatf("v%0d_winner", idx), 32'(winner), 32'(v.exp_win));
        checkOutput($sformatf("v%0d_winner_valid", idx), 32'(winner_valid), 32'(v.exp_wv));
        checkOutput($sformatf("v%0d_x_final", idx), 32'({x[3], x[2], x[1], x[0]}), 32'(v.exp_x));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_done_width", idx), 32'({busy, done}), 32'b00);
        checkOutput($sformatf("v%0d_mult_pulses", idx), 32'(mult_cnt - m0), 32'(v.exp_iter));
        checkOutput($sformatf("v%0d_add_pulses", idx), 32'(add_cnt - a0), 32'(v.exp_iter));
        checkOutput($sformatf("v%0d_done_pulses", idx), 32'(done_cnt - d0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d_winner_hold", idx), 32'({winner_valid, winner}), 32'({v.exp_wv, v.exp_win}));
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) in_x[i] = 5'd0;
        cur = mkVec('0, '0, '0, 0, 4'd0, 2'd0, 1'b0, '0);

        //          in_x {x3..x0}                       keep {x3..x0}                       zero {it4..it1}                     lat it  win wv exp_x
        vecs[0] = mkVec({5'b00110,5'b00100,5'b11100,5'b00010}, {5'b00011,5'b0,5'b0,5'b0},
                        {4'b0000,4'b0000,4'b0000,4'b0111}, 5, 4'd1, 2'd3, 1'b1, {5'b00011,5'b0,5'b0,5'b0});
        vecs[1] = mkVec({5'b00111,5'b00110,5'b00101,5'b00100}, {5'b01011,5'b01010,5'b01001,5'b01000},
                        {4'b0000,4'b0111,4'b0011,4'b0001}, 13, 4'd3, 2'd3, 1'b1, {5'b01011,5'b0,5'b0,5'b0});
        vecs[2] = mkVec({5'b00100,5'b00011,5'b00010,5'b00001}, {5'b11111,5'b00011,5'b00010,5'b00001},
                        {4'b0000,4'b0000,4'b0000,4'b0000}, 17, 4'd4, 2'd0, 1'b1, {5'b11111,5'b00011,5'b00010,5'b00001});
        vecs[3] = mkVec({5'b00001,5'b00001,5'b00001,5'b00001}, {5'b00101,5'b00101,5'b00101,5'b00101},
                        {4'b0000,4'b0000,4'b0000,4'b1111}, 5, 4'd1, 2'd0, 1'b0, {5'b0,5'b0,5'b0,5'b0});
        vecs[4] = mkVec({5'b0,5'b01000,5'b0,5'b0}, {5'b0,5'b01000,5'b0,5'b0},
                        {4'b0000,4'b0000,4'b0000,4'b1011}, 5, 4'd1, 2'd2, 1'b1, {5'b0,5'b01000,5'b0,5'b0});
        vecs[5] = mkVec({5'b00001,5'b11000,5'b00111,5'b00010}, {5'b00001,5'b11000,5'b00111,5'b00010},
                        {4'b1001,4'b1001,4'b1001,4'b1001}, 17, 4'd4, 2'd1, 1'b1, {5'b0,5'b11000,5'b00111,5'b0});

        // Reset for two cycles, then idle quietly.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_quiet", allOutputs(), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            runAndCheck(i, 1'b0);
        end

        $display("[TB] start pulsed during ADD");
        runAndCheck(1, 1'b1);

        $display("[TB] reset during CHECK of iteration 2");
        cur       = vecs[1];
        base_mult = mult_cnt;
        d0        = done_cnt;
        @(negedge clk);
        for (int i = 0; i < 4; i++) in_x[i] = vecs[1].in_x[i];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("rst_pre_busy", 32'({busy, done, mult_reg_en, add_reg_en}), 32'b1000);
        checkOutput("rst_pre_iter", 32'(iter_count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_mid_run_outputs", allOutputs(), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("rst_stays_idle", allOutputs(), 32'd0);
        runAndCheck(0, 1'b0);

        checkOutput("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
